game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter: WDT_CYCLES, 255, max cycles spent in WAIT before watchdog fault (range 2..255).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: i_restart  input  1  synchronous game restart, active-high.
REQ-005 SHALL have port: i_start  input  1  level; first user direction received.
REQ-006 SHALL have port: i_pause  input  1  level; pause request.
REQ-007 SHALL have port: i_tick_req  input  1  single-cycle pulse from tick generator.
REQ-008 SHALL have port: i_apple_ready  input  1  level; apple placement valid.
REQ-009 SHALL have port: i_tick_done  input  1  single-cycle pulse; snake finished move.
REQ-010 SHALL have port: i_snake_failure  input  1  pulse; collision detected.
REQ-011 SHALL have port: i_snake_success  input  1  pulse; board filled.
REQ-012 SHALL have port: o_tick  output  1  single-cycle move command to snake.
REQ-013 SHALL have port: o_busy  output  1  high in TICK or WAIT.
REQ-014 SHALL have port: o_failure  output  1  high in FAIL.
REQ-015 SHALL have port: o_success  output  1  high in WIN.
REQ-016 SHALL have port: o_state  output  3  encoded state.
REQ-017 SHALL have port: o_drop_cnt  output  8  saturating count of dropped tick requests.
REQ-018 SHALL have port: o_wdt_fault  output  1  sticky watchdog fault flag.

Function
REQ-019 SHALL implement states IDLE=0, RUN=1, TICK=2, WAIT=3, PAUSE=4, FAIL=5, WIN=6; o_state SHALL equal the state register.
REQ-020 IDLE SHALL go to RUN when i_start=1; all other inputs ignored in IDLE.
REQ-021 In RUN, priority SHALL be: i_snake_failure -> FAIL; i_snake_success -> WIN; i_pause -> PAUSE; i_tick_req & i_apple_ready -> TICK.
REQ-022 RUN with i_tick_req=1 and i_apple_ready=0 SHALL stay in RUN and increment o_drop_cnt.
REQ-023 o_tick SHALL be a Moore output, high exactly one cycle (state TICK), asserted the cycle after i_tick_req is sampled; TICK SHALL always advance to WAIT.
REQ-024 WAIT SHALL return to RUN on i_tick_done; i_tick_req in TICK or WAIT SHALL increment o_drop_cnt.
REQ-025 PAUSE SHALL return to RUN when i_pause=0; i_tick_req in PAUSE SHALL be discarded without counting.
REQ-026 i_snake_failure SHALL force FAIL from RUN, TICK, WAIT, PAUSE; i_snake_success SHALL force WIN likewise; simultaneous failure and success SHALL yield FAIL.
REQ-027 Failure/success SHALL take priority over i_tick_done, i_pause and i_tick_req in the same cycle.
REQ-028 FAIL and WIN SHALL be terminal until i_restart or reset.
REQ-029 o_drop_cnt SHALL saturate at 255 and never wrap.
REQ-030 o_failure, o_success, o_busy SHALL decode combinationally from the state register only.

Reset
REQ-031 rst_n=0 SHALL set state IDLE, o_drop_cnt=0, o_wdt_fault=0, watchdog counter 0; hence o_tick=o_busy=o_failure=o_success=0.
REQ-032 i_restart=1 SHALL have the same effect as rst_n=0 except o_drop_cnt SHALL be retained.
REQ-033 Reset/restart mid-TICK or mid-WAIT SHALL abort the pending move; a late i_tick_done afterwards SHALL be ignored.

Configuration
REQ-034 With GAME_SEQ_WATCHDOG_EN defined, a counter SHALL clear on WAIT entry, increment each WAIT cycle, and on reaching WDT_CYCLES without i_tick_done SHALL force FAIL and set o_wdt_fault.
REQ-035 Without GAME_SEQ_WATCHDOG_EN, WAIT SHALL persist indefinitely, no watchdog counter SHALL exist, and o_wdt_fault SHALL be constant 0.

Verification
REQ-036 Reset, i_start=1, i_apple_ready=1, i_tick_req pulse at cycle N -> o_tick=1 only at N+1, o_busy=1 until i_tick_done, then o_state=1.
REQ-037 RUN, i_apple_ready=0, 300 i_tick_req pulses -> no o_tick, o_drop_cnt=255.
REQ-038 WAIT, i_tick_done and i_snake_failure same cycle -> o_state=5, o_failure=1; later i_tick_req -> no o_tick.
REQ-039 RUN, i_pause=1 with 3 i_tick_req pulses -> o_state=4, o_drop_cnt unchanged; i_pause=0 -> o_state=1 next cycle.
REQ-040 Watchdog enabled, WDT_CYCLES=10, no i_tick_done -> o_state=5 and o_wdt_fault=1 after 10 WAIT cycles; i_restart -> o_state=0, o_wdt_fault=0, o_drop_cnt kept.

Source files
------------

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game move sequencer FSM with dropped-tick counter
// Define GAME_SEQ_WATCHDOG_EN to build in the WAIT-state watchdog (limit WDT_CYCLES).
module game_sequencer #(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_restart,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_tick_req,
  input  logic       i_apple_ready,
  input  logic       i_tick_done,
  input  logic       i_snake_failure,
  input  logic       i_snake_success,
  output logic       o_tick,
  output logic       o_busy,
  output logic       o_failure,
  output logic       o_success,
  output logic [2:0] o_state,
  output logic [7:0] o_drop_cnt,
  output logic       o_wdt_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_TICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_PAUSE = 3'd4,
    S_FAIL  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  state_t     r_state;
  logic [7:0] r_drop_cnt;
  logic       w_abort;
  state_t     w_abort_state;
  logic       w_drop;

  assign w_abort       = i_snake_failure | i_snake_success;
  assign w_abort_state = i_snake_failure ? S_FAIL : S_WIN;

  // A request is dropped when it cannot start a move; pause discards silently
  assign w_drop = i_tick_req & ~w_abort &
                  (((r_state == S_RUN) & ~i_pause & ~i_apple_ready) |
                   (r_state == S_TICK) | (r_state == S_WAIT));

`ifdef GAME_SEQ_WATCHDOG_EN
  localparam logic [7:0] WDT_LAST = 8'(WDT_CYCLES - 1);
  logic [7:0] r_wdt_cnt;
  logic       r_wdt_fault;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (!i_restart && w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_restart) begin
      r_state <= S_IDLE;
`ifdef GAME_SEQ_WATCHDOG_EN
      r_wdt_cnt   <= 8'd0;
      r_wdt_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_abort)                          r_state <= w_abort_state;
          else if (i_pause)                     r_state <= S_PAUSE;
          else if (i_tick_req && i_apple_ready) r_state <= S_TICK;
        end
        S_TICK: begin
          r_state <= w_abort ? w_abort_state : S_WAIT;
`ifdef GAME_SEQ_WATCHDOG_EN
          r_wdt_cnt <= 8'd0;
`endif
        end
        S_WAIT: begin
          if (w_abort)          r_state <= w_abort_state;
          else if (i_tick_done) r_state <= S_RUN;
`ifdef GAME_SEQ_WATCHDOG_EN
          else if (r_wdt_cnt == WDT_LAST) begin
            r_state     <= S_FAIL;
            r_wdt_fault <= 1'b1;
          end else begin
            r_wdt_cnt <= r_wdt_cnt + 8'd1;
          end
`endif
        end
        S_PAUSE: begin
          if (w_abort)       r_state <= w_abort_state;
          else if (!i_pause) r_state <= S_RUN;
        end
        S_FAIL, S_WIN: r_state <= r_state;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_tick     = (r_state == S_TICK);
  assign o_busy     = (r_state == S_TICK) | (r_state == S_WAIT);
  assign o_failure  = (r_state == S_FAIL);
  assign o_success  = (r_state == S_WIN);
  assign o_drop_cnt = r_drop_cnt;

`ifdef GAME_SEQ_WATCHDOG_EN
  assign o_wdt_fault = r_wdt_fault;
`else
  // WDT_CYCLES only matters when the watchdog is built in
  assign o_wdt_fault = 1'b0 & (WDT_CYCLES > 255);
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
// Watchdog checks run when GAME_SEQ_WATCHDOG_EN is defined (WDT_CYCLES=10).
module tb_game_sequencer;

  localparam int WDT = 10;

  logic       clk = 1'b0;
  logic       rst_n, i_restart, i_start, i_pause, i_tick_req, i_apple_ready;
  logic       i_tick_done, i_snake_failure, i_snake_success;
  logic       o_tick, o_busy, o_failure, o_success, o_wdt_fault;
  logic [2:0] o_state;
  logic [7:0] o_drop_cnt;

  always #5 clk = ~clk;

  game_sequencer #(.WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst_n(rst_n), .i_restart(i_restart), .i_start(i_start),
    .i_pause(i_pause), .i_tick_req(i_tick_req), .i_apple_ready(i_apple_ready),
    .i_tick_done(i_tick_done), .i_snake_failure(i_snake_failure),
    .i_snake_success(i_snake_success), .o_tick(o_tick), .o_busy(o_busy),
    .o_failure(o_failure), .o_success(o_success), .o_state(o_state),
    .o_drop_cnt(o_drop_cnt), .o_wdt_fault(o_wdt_fault)
  );

  typedef struct {
    logic rst_n, restart, start, pause, tick_req, apple, done, fail, succ;
  } stim_t;

  typedef struct {
    stim_t s;
    int    exp_state;
    int    exp_drop;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game state as spec numbers, drop tally, fault flag, WAIT time spent
  int m_state, m_drop, m_fault, m_waitc;

  function automatic stim_t mk(bit r, bit re, bit st, bit pa, bit tr, bit ap, bit dn, bit fl, bit sc);
    stim_t s;
    s.rst_n = r; s.restart = re; s.start = st; s.pause = pa; s.tick_req = tr;
    s.apple = ap; s.done = dn; s.fail = fl; s.succ = sc;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input stim_t s);
    bit hit, in_play;
    if (!s.rst_n) begin
      m_state = 0; m_drop = 0; m_fault = 0; m_waitc = 0;
      return;
    end
    if (s.restart) begin
      m_state = 0; m_fault = 0; m_waitc = 0;
      return;
    end
    hit     = s.fail || s.succ;
    in_play = (m_state >= 1) && (m_state <= 4);
    if (s.tick_req && !hit &&
        ((m_state == 1 && !s.pause && !s.apple) || m_state == 2 || m_state == 3))
      m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    if (in_play && hit) begin
      m_state = s.fail ? 5 : 6;
      return;
    end
    case (m_state)
      0: if (s.start) m_state = 1;
      1: begin
        if (s.pause) m_state = 4;
        else if (s.tick_req && s.apple) m_state = 2;
      end
      2: begin m_state = 3; m_waitc = 0; end
      3: begin
        if (s.done) m_state = 1;
        else begin
          m_waitc++;
`ifdef GAME_SEQ_WATCHDOG_EN
          if (m_waitc >= WDT) begin m_state = 5; m_fault = 1; end
`endif
        end
      end
      4: if (!s.pause) m_state = 1;
      default: ;
    endcase
  endtask

  task automatic check_model();
    chk("model_state",   o_state,     m_state);
    chk("model_tick",    o_tick,      m_state == 2);
    chk("model_busy",    o_busy,      (m_state == 2) || (m_state == 3));
    chk("model_failure", o_failure,   m_state == 5);
    chk("model_success", o_success,   m_state == 6);
    chk("model_drop",    o_drop_cnt,  m_drop);
    chk("model_wdt",     o_wdt_fault, m_fault);
  endtask

  task automatic step(input stim_t s);
    rst_n = s.rst_n; i_restart = s.restart; i_start = s.start; i_pause = s.pause;
    i_tick_req = s.tick_req; i_apple_ready = s.apple; i_tick_done = s.done;
    i_snake_failure = s.fail; i_snake_success = s.succ;
    @(posedge clk);
    model_step(s);
    #1;
    check_model();
  endtask

  task automatic reset_and_start();
    stim_t s;
    s = idle(); s.rst_n = 0; step(s);
    s = idle(); s.start = 1; step(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  tbl[19];
    stim_t s;
    bit    saw_tick;

    m_state = 0; m_drop = 0; m_fault = 0; m_waitc = 0;
    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0), 0, 0};
    tbl[1]  = '{mk(1,0,0,0,1,0,0,0,0), 0, 0};
    tbl[2]  = '{mk(1,0,1,0,0,0,0,0,0), 1, 0};
    tbl[3]  = '{mk(1,0,0,0,1,0,0,0,0), 1, 1};
    tbl[4]  = '{mk(1,0,0,0,1,1,0,0,0), 2, 1};
    tbl[5]  = '{mk(1,0,0,0,1,1,0,0,0), 3, 2};
    tbl[6]  = '{mk(1,0,0,0,1,0,0,0,0), 3, 3};
    tbl[7]  = '{mk(1,0,0,0,0,0,1,0,0), 1, 3};
    tbl[8]  = '{mk(1,0,0,1,1,0,0,0,0), 4, 3};
    tbl[9]  = '{mk(1,0,0,1,1,0,0,0,0), 4, 3};
    tbl[10] = '{mk(1,0,0,0,0,0,0,0,0), 1, 3};
    tbl[11] = '{mk(1,0,0,0,1,1,0,0,0), 2, 3};
    tbl[12] = '{mk(1,0,0,0,0,0,0,1,1), 5, 3};
    tbl[13] = '{mk(1,0,0,0,1,1,0,0,0), 5, 3};
    tbl[14] = '{mk(1,1,0,0,0,0,0,0,0), 0, 3};
    tbl[15] = '{mk(1,0,1,0,0,0,0,0,0), 1, 3};
    tbl[16] = '{mk(1,0,0,0,0,0,0,0,1), 6, 3};
    tbl[17] = '{mk(1,0,1,0,0,0,0,0,0), 6, 3};
    tbl[18] = '{mk(0,0,0,0,0,0,0,0,0), 0, 0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s);
      chk($sformatf("vec%0d_state", i), o_state,    tbl[i].exp_state);
      chk($sformatf("vec%0d_tick", i),  o_tick,     tbl[i].exp_state == 2);
      chk($sformatf("vec%0d_drop", i),  o_drop_cnt, tbl[i].exp_drop);
    end

    // Move handshake: tick exactly one cycle after the request, busy until done
    reset_and_start();
    s = idle(); s.apple = 1;
    for (int i = 0; i < 3; i++) begin step(s); chk("mv_pre_tick", o_tick, 0); end
    s.tick_req = 1; step(s);
    chk("mv_tick", o_tick, 1);
    chk("mv_busy_tick", o_busy, 1);
    s.tick_req = 0;
    for (int i = 0; i < 5; i++) begin
      step(s);
      chk("mv_no_tick", o_tick, 0);
      chk("mv_busy_wait", o_busy, 1);
    end
    s.done = 1; step(s);
    chk("mv_back_run", o_state, 1);
    chk("mv_not_busy", o_busy, 0);

    // 300 requests without an apple saturate the drop counter
    reset_and_start();
    saw_tick = 0;
    for (int i = 0; i < 300; i++) begin
      s = idle(); s.tick_req = 1; step(s); saw_tick |= o_tick;
      s = idle(); step(s); saw_tick |= o_tick;
    end
    chk("sat_no_tick", saw_tick, 0);
    chk("sat_drop", o_drop_cnt, 255);

    // Failure beats tick_done in WAIT; later requests do nothing
    reset_and_start();
    s = idle(); s.tick_req = 1; s.apple = 1; step(s);
    s = idle(); step(s);
    chk("fd_in_wait", o_state, 3);
    s = idle(); s.done = 1; s.fail = 1; step(s);
    chk("fd_state", o_state, 5);
    chk("fd_failure", o_failure, 1);
    saw_tick = 0;
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.tick_req = (i % 2 == 0); s.apple = 1; step(s); saw_tick |= o_tick;
    end
    chk("fd_no_tick", saw_tick, 0);

    // Pause discards requests without counting
    reset_and_start();
    s = idle(); s.tick_req = 1; step(s);
    chk("pz_drop_before", o_drop_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      s = idle(); s.pause = 1; s.tick_req = (i % 2 == 0); step(s);
    end
    chk("pz_state", o_state, 4);
    chk("pz_drop", o_drop_cnt, 1);
    s = idle(); step(s);
    chk("pz_resume", o_state, 1);

    // Restart mid-TICK and reset mid-WAIT abort the move; late done ignored
    reset_and_start();
    s = idle(); s.tick_req = 1; s.apple = 1; step(s);
    s = idle(); s.restart = 1; step(s);
    chk("ab_restart_idle", o_state, 0);
    s = idle(); s.done = 1; step(s);
    chk("ab_late_done", o_state, 0);
    s = idle(); s.start = 1; step(s);
    s = idle(); s.tick_req = 1; s.apple = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.rst_n = 0; step(s);
    chk("ab_reset_idle", o_state, 0);
    s = idle(); s.done = 1; step(s);
    chk("ab_reset_late_done", o_state, 0);
    chk("ab_reset_busy", o_busy, 0);

`ifdef GAME_SEQ_WATCHDOG_EN
    // Watchdog fires after WDT WAIT cycles; restart clears the fault, keeps drops
    reset_and_start();
    s = idle(); s.tick_req = 1; step(s);
    s = idle(); s.tick_req = 1; s.apple = 1; step(s);
    s = idle(); step(s);
    for (int i = 0; i < WDT - 1; i++) step(s);
    chk("wd_still_wait", o_state, 3);
    step(s);
    chk("wd_state", o_state, 5);
    chk("wd_fault", o_wdt_fault, 1);
    s = idle(); s.restart = 1; step(s);
    chk("wd_restart_state", o_state, 0);
    chk("wd_restart_fault", o_wdt_fault, 0);
    chk("wd_restart_drop", o_drop_cnt, 1);
`else
    // Without the watchdog a long WAIT persists
    reset_and_start();
    s = idle(); s.tick_req = 1; s.apple = 1; step(s);
    s = idle();
    for (int i = 0; i < 300; i++) step(s);
    chk("nowd_wait", o_state, 3);
    chk("nowd_fault", o_wdt_fault, 0);
`endif

    // Randomized run against the reference model
    s = idle(); s.rst_n = 0; step(s);
    for (int i = 0; i < 3000; i++) begin
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.restart  = ($urandom_range(0, 79) == 0);
      s.start    = ($urandom_range(0, 3) == 0);
      s.pause    = ($urandom_range(0, 5) == 0);
      s.tick_req = ($urandom_range(0, 2) == 0);
      s.apple    = ($urandom_range(0, 3) != 0);
      s.done     = ($urandom_range(0, 3) == 0);
      s.fail     = ($urandom_range(0, 59) == 0);
      s.succ     = ($urandom_range(0, 79) == 0);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
